// File: rtl/simon_core.sv
// simon_core: iterative Simon block cipher (encrypt/decrypt) with an internal round-key store.
// The key is expanded once per load, then reused for any number of blocks, one round per cycle.
module simon_core #(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned KEY_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KEY_WORDS*WORD_W-1:0] key_in,
    input  logic                        key_load,
    output logic                        key_load_rdy,
    output logic                        key_vld,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_decrypt,
    input  logic [2*WORD_W-1:0]         in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_W-1:0]         out_data
);

    localparam bit CFG_OK = (WORD_W == 32 && (KEY_WORDS == 3 || KEY_WORDS == 4)) ||
                            (WORD_W == 64 && KEY_WORDS >= 2 && KEY_WORDS <= 4);
    localparam int unsigned ROUNDS = (WORD_W == 32) ? ((KEY_WORDS == 3) ? 42 : 44) :
                                     (KEY_WORDS == 2) ? 68 : (KEY_WORDS == 3) ? 69 : 72;
    localparam int unsigned CNT_W = $clog2(ROUNDS);

    // Constant sequences, leftmost character is bit index 0 of the sequence.
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] Z_SEQ = (WORD_W == 64 && KEY_WORDS == 4) ? Z4 :
                                    ((WORD_W == 32 && KEY_WORDS == 3) ||
                                     (WORD_W == 64 && KEY_WORDS == 2)) ? Z2 : Z3;
    localparam logic [CNT_W:0] Z_LEN = (CNT_W + 1)'(62);

    if (!CFG_OK) begin : g_bad_cfg
        $error("simon_core: unsupported WORD_W/KEY_WORDS combination");
    end

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned s);
        return (v << s) | (v >> (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned s);
        return (v >> s) | (v << (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] round_f(input logic [WORD_W-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    typedef enum logic [2:0] {StNokey, StExpand, StReady, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  x_q, y_q;
    logic               dec_q;
    logic [2*WORD_W-1:0] out_data_q;
    logic [WORD_W-1:0]  ks [ROUNDS];

    logic               key_accept, blk_accept, expand_last, run_last;
    logic [CNT_W-1:0]   addr_hi, addr_p1, addr_wr, addr_rk;
    logic [CNT_W:0]     z_full;
    logic [5:0]         z_idx;
    logic               z_bit;
    logic [WORD_W-1:0]  tmp, new_word, rk, x_nxt, y_nxt;

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d      = state_q;
        key_load_rdy = (state_q == StNokey) || (state_q == StReady);
        key_vld      = (state_q == StReady) || (state_q == StRun) || (state_q == StDone);
        in_ready     = (state_q == StReady) && !key_load;
        out_valid    = (state_q == StDone);
        key_accept   = key_load && key_load_rdy;
        blk_accept   = in_valid && in_ready;
        expand_last  = (cnt_q == CNT_W'(ROUNDS - KEY_WORDS - 1));
        run_last     = (cnt_q == CNT_W'(ROUNDS - 1));
        unique case (state_q)
            StNokey:  if (key_load) state_d = StExpand;
            StExpand: if (expand_last) state_d = StReady;
            StReady: begin
                // A key load in the same cycle as a block request wins.
                if (key_load)      state_d = StExpand;
                else if (in_valid) state_d = StRun;
            end
            StRun:    if (run_last) state_d = StDone;
            StDone:   if (out_ready) state_d = StReady;
            default:  state_d = StNokey;
        endcase
    end

    // Key-schedule word and round datapath.
    always_comb begin
        addr_hi = cnt_q + CNT_W'(KEY_WORDS - 1);
        addr_p1 = cnt_q + CNT_W'(1);
        addr_wr = cnt_q + CNT_W'(KEY_WORDS);
        addr_rk = dec_q ? (CNT_W'(ROUNDS - 1) - cnt_q) : cnt_q;
        // Sequence position wraps every 62 words (only reachable for 64-bit words).
        z_full  = {1'b0, cnt_q};
        if (z_full >= Z_LEN) z_full = z_full - Z_LEN;
        z_idx   = z_full[5:0];
        z_bit   = Z_SEQ[6'd61 - z_idx];
        tmp     = ror(ks[addr_hi], 3);
        if (KEY_WORDS == 4) tmp = tmp ^ ks[addr_p1];
        tmp      = tmp ^ ror(tmp, 1);
        new_word = ~ks[cnt_q] ^ tmp ^ WORD_W'(z_bit) ^ WORD_W'(3);
        rk       = ks[addr_rk];
        if (dec_q) begin
            x_nxt = y_q;
            y_nxt = x_q ^ round_f(y_q) ^ rk;
        end else begin
            x_nxt = y_q ^ round_f(x_q) ^ rk;
            y_nxt = x_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StNokey;
        else      state_q <= state_d;
    end

    // Round-key store: key words on load, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (key_accept) begin
            for (int j = 0; j < int'(KEY_WORDS); j++) begin
                ks[CNT_W'(j)] <= key_in[j*WORD_W +: WORD_W];
            end
        end else if (state_q == StExpand) begin
            ks[addr_wr] <= new_word;
        end
    end

    // Counter, working block and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dec_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (key_accept) begin
                cnt_q <= '0;
            end else if (blk_accept) begin
                cnt_q <= '0;
                x_q   <= in_data[2*WORD_W-1:WORD_W];
                y_q   <= in_data[WORD_W-1:0];
                dec_q <= in_decrypt;
            end else if ((state_q == StExpand && !expand_last) || (state_q == StRun && !run_last)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (state_q == StExpand || state_q == StRun) begin
                cnt_q <= '0;
            end
            if (state_q == StRun) begin
                x_q <= x_nxt;
                y_q <= y_nxt;
                if (run_last) out_data_q <= {x_nxt, y_nxt};
            end
        end
    end

    assign out_data = out_data_q;

endmodule
